// File: rtl/st_mm_burst_writer_pkg.sv
// Shared types and helpers for the stream-to-memory burst writer and its FIFO.
package st_mm_burst_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned bytes_per_word(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // burstcount must be able to hold BURST_LEN itself, not just BURST_LEN-1
   function automatic int unsigned burstcount_width(input int unsigned burst_len);
      return clog2(burst_len) + 1;
   endfunction

endpackage

// File: rtl/st_mm_burst_writer_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy count.
module st_sync_fifo
   import st_mm_burst_writer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   push_data,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   head,
   output logic [clog2(DEPTH):0]   count
);

   localparam int unsigned PW = clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && (count != CW'(DEPTH));
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/st_mm_burst_writer.sv
// Drains an Avalon-ST stream into Avalon-MM memory as fixed-size incrementing bursts.
module st_mm_burst_writer
   import st_mm_burst_writer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [ADDR_WIDTH-1:0]                  base_addr,
   input  logic [LEN_WIDTH-1:0]                   num_words,
   output logic                                   busy,
   output logic                                   done,
   input  logic                                   asi_valid,
   input  logic [DATA_WIDTH-1:0]                  asi_data,
   output logic                                   asi_ready,
   output logic [ADDR_WIDTH-1:0]                  avm_address,
   output logic                                   avm_write,
   output logic [DATA_WIDTH-1:0]                  avm_writedata,
   output logic [burstcount_width(BURST_LEN)-1:0] avm_burstcount,
   output logic [DATA_WIDTH/8-1:0]                avm_byteenable,
   input  logic                                   avm_waitrequest
);

   localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);
   localparam int unsigned BCW = burstcount_width(BURST_LEN);
   localparam int unsigned CW  = clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPW - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
   logic [LEN_WIDTH-1:0]  accepted, accepted_nxt;
   logic [LEN_WIDTH-1:0]  total, total_nxt;
   logic [BCW-1:0]        beat, beat_nxt;
   logic [BCW-1:0]        bw_c;
   logic [ADDR_WIDTH-1:0] avm_address_nxt;
   logic [BCW-1:0]        avm_burstcount_nxt;
   logic                  busy_nxt, done_nxt, asi_ready_nxt, avm_write_nxt;
   logic                  push_c, pop_c;
   logic [CW-1:0]         fifo_count, count_nxt;

   assign avm_byteenable = '1;
   assign push_c         = asi_valid && asi_ready;
   assign pop_c          = avm_write && !avm_waitrequest;

   st_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .push_data (asi_data),
      .pop       (pop_c),
      .head      (avm_writedata),
      .count     (fifo_count)
   );

   // Next-state, counters and the next value of every registered output
   always_comb begin
      state_nxt          = state;
      addr_nxt           = addr;
      remaining_nxt      = remaining;
      total_nxt          = total;
      beat_nxt           = beat;
      avm_address_nxt    = avm_address;
      avm_burstcount_nxt = avm_burstcount;
      accepted_nxt       = accepted + LEN_WIDTH'(push_c);
      bw_c               = (remaining < LEN_WIDTH'(BURST_LEN)) ? BCW'(remaining) : BCW'(BURST_LEN);

      case (state)
         IDLE: begin
            if (start) begin
               addr_nxt      = base_addr & ALIGN_MASK;
               remaining_nxt = num_words;
               total_nxt     = num_words;
               accepted_nxt  = '0;
               beat_nxt      = '0;
               state_nxt     = (num_words == '0) ? DONE : ARM;
            end
         end
         ARM: begin
            if (fifo_count >= CW'(bw_c)) begin
               avm_address_nxt    = addr;
               avm_burstcount_nxt = bw_c;
               beat_nxt           = '0;
               state_nxt          = BURST;
            end
         end
         BURST: begin
            if (pop_c) begin
               if (beat == avm_burstcount - BCW'(1)) begin
                  addr_nxt      = addr + ADDR_WIDTH'(avm_burstcount) * ADDR_WIDTH'(BPW);
                  remaining_nxt = remaining - LEN_WIDTH'(avm_burstcount);
                  beat_nxt      = '0;
                  state_nxt     = (remaining == LEN_WIDTH'(avm_burstcount)) ? DONE : ARM;
               end else begin
                  beat_nxt = beat + BCW'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are registered, so derive them from the next state and next count
      count_nxt     = fifo_count + CW'(push_c) - CW'(pop_c);
      busy_nxt      = (state_nxt != IDLE);
      done_nxt      = (state_nxt == DONE);
      avm_write_nxt = (state_nxt == BURST);
      asi_ready_nxt = ((state_nxt == ARM) || (state_nxt == BURST)) &&
                      (count_nxt < CW'(FIFO_DEPTH)) && (accepted_nxt < total_nxt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         addr           <= '0;
         remaining      <= '0;
         accepted       <= '0;
         total          <= '0;
         beat           <= '0;
         avm_address    <= '0;
         avm_burstcount <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         asi_ready      <= 1'b0;
         avm_write      <= 1'b0;
      end else begin
         state          <= state_nxt;
         addr           <= addr_nxt;
         remaining      <= remaining_nxt;
         accepted       <= accepted_nxt;
         total          <= total_nxt;
         beat           <= beat_nxt;
         avm_address    <= avm_address_nxt;
         avm_burstcount <= avm_burstcount_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         asi_ready      <= asi_ready_nxt;
         avm_write      <= avm_write_nxt;
      end
   end

endmodule

// File: tb/tb_st_mm_burst_writer.sv
// Bench for st_mm_burst_writer: directed and randomized transfers against a burst-list model.
module tb_st_mm_burst_writer;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 32;
   localparam int unsigned LW  = 16;
   localparam int unsigned BL  = 8;
   localparam int unsigned FD  = 16;
   localparam int unsigned BCW = 4;
   localparam int unsigned BEW = DW / 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [AW-1:0]  base_addr;
   logic [LW-1:0]  num_words;
   logic           busy, done;
   logic           asi_valid, asi_ready;
   logic [DW-1:0]  asi_data;
   logic [AW-1:0]  avm_address;
   logic           avm_write;
   logic [DW-1:0]  avm_writedata;
   logic [BCW-1:0] avm_burstcount;
   logic [BEW-1:0] avm_byteenable;
   logic           avm_waitrequest;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   st_mm_burst_writer #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .LEN_WIDTH (LW),
      .BURST_LEN (BL), .FIFO_DEPTH (FD)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .base_addr (base_addr),
      .num_words (num_words), .busy (busy), .done (done),
      .asi_valid (asi_valid), .asi_data (asi_data), .asi_ready (asi_ready),
      .avm_address (avm_address), .avm_write (avm_write),
      .avm_writedata (avm_writedata), .avm_burstcount (avm_burstcount),
      .avm_byteenable (avm_byteenable), .avm_waitrequest (avm_waitrequest)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One command from start to completion; stall_mode 0 none, 1 random, 2 one long stall after 3 beats
   task automatic run_xfer(input logic [31:0] base, input int n, input bit seq_data,
                           input int valid_pct, input int stall_mode, input bit poke,
                           input int abort_at);
      logic [31:0] gen[$];
      logic [31:0] bd[$];
      logic [31:0] ba[$];
      logic [3:0]  bc[$];
      logic [31:0] eb_addr[$];
      int          eb_cnt[$];
      logic [31:0] ea, prev_d, prev_a;
      logic [3:0]  prev_c;
      int k = 0, nb = 0, cyc = 0, rem, b, bi;
      int done_cnt = 0, done_cyc = -1, last_beat = -1, rises = 0, occ, occ_max = 0;
      int stall_left = 0;
      bit stall_used = 0, prev_w = 0, prev_stall = 0, fin = 0, aborted = 0;

      for (int i = 0; i < n + 4; i++) gen.push_back(seq_data ? 32'(i) : $urandom);
      ea  = base & 32'hFFFF_FFFC;
      rem = n;
      while (rem > 0) begin
         b = (rem < int'(BL)) ? rem : int'(BL);
         eb_addr.push_back(ea);
         eb_cnt.push_back(b);
         ea  = ea + 32'(b * 4);
         rem = rem - b;
      end
      prev_d = '0; prev_a = '0; prev_c = '0;

      base_addr = base; num_words = LW'(n); start = 1'b1;
      asi_valid = 1'b0; avm_waitrequest = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;

      while (!fin && cyc < 3000) begin
         if (poke && cyc == 6) begin
            start = 1'b1; base_addr = 32'h5000; num_words = LW'(3);
         end else begin
            start = 1'b0; base_addr = base; num_words = LW'(n);
         end
         if (abort_at > 0 && nb == abort_at) begin
            reset = 1'b1; asi_valid = 1'b0; avm_waitrequest = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0; avm_waitrequest = 1'b0;
            chk("abort_write", 64'(avm_write), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_ready", 64'(asi_ready), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            aborted = 1; fin = 1;
            break;
         end
         asi_valid = (k < gen.size()) && ($urandom_range(99) < 32'(valid_pct));
         asi_data  = (k < gen.size()) ? gen[k] : '0;
         if (stall_mode == 2 && nb == 3 && !stall_used) begin
            stall_left = 8; stall_used = 1;
         end
         if (stall_mode == 1) avm_waitrequest = ($urandom_range(99) < 30);
         else if (stall_left > 0) begin
            avm_waitrequest = 1'b1; stall_left--;
         end else avm_waitrequest = 1'b0;

         @(negedge clk);
         if (prev_w && prev_stall) begin
            chk("stall_write_held", 64'(avm_write), 64'd1);
            chk("stall_data_held", 64'(avm_writedata), 64'(prev_d));
            chk("stall_addr_held", 64'(avm_address), 64'(prev_a));
            chk("stall_bc_held", 64'(avm_burstcount), 64'(prev_c));
         end
         occ = k - nb;
         if (occ > occ_max) occ_max = occ;
         if (occ == int'(FD)) chk("ready_at_full", 64'(asi_ready), 64'd0);
         else if (busy && !done && k < n) chk("ready_open", 64'(asi_ready), 64'd1);
         if (k >= n && busy) chk("ready_after_last", 64'(asi_ready), 64'd0);
         if (avm_write && !prev_w) rises++;
         if (asi_valid && asi_ready) k++;
         if (avm_write && !avm_waitrequest) begin
            bd.push_back(avm_writedata); ba.push_back(avm_address); bc.push_back(avm_burstcount);
            nb++; last_beat = cyc;
         end
         if (done) begin
            done_cnt++; done_cyc = cyc;
            chk("busy_at_done", 64'(busy), 64'd1);
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("done_one_cycle", 64'(done), 64'd0);
            fin = 1;
         end
         prev_w = avm_write; prev_stall = avm_waitrequest;
         prev_d = avm_writedata; prev_a = avm_address; prev_c = avm_burstcount;
         @(posedge clk); #1;
         cyc++;
      end
      asi_valid = 1'b0; avm_waitrequest = 1'b0; start = 1'b0;
      if (!fin) chk("timeout", 64'd0, 64'd1);
      if (aborted || !fin) return;

      chk("words_accepted", 64'(k), 64'(n));
      chk("beats_written", 64'(nb), 64'(n));
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("burst_count", 64'(rises), 64'(eb_addr.size()));
      if (n > 0) chk("done_after_last_beat", 64'(done_cyc), 64'(last_beat + 1));
      else chk("zero_len_done_first", 64'(done_cyc), 64'd0);
      if (stall_mode == 2) chk("fifo_filled", 64'(occ_max), 64'(FD));
      bi = 0;
      for (int j = 0; j < eb_addr.size(); j++) begin
         for (int m = 0; m < eb_cnt[j]; m++) begin
            if (bi < nb) begin
               chk($sformatf("beat%0d_addr", bi), 64'(ba[bi]), 64'(eb_addr[j]));
               chk($sformatf("beat%0d_bc", bi), 64'(bc[bi]), 64'(eb_cnt[j]));
               chk($sformatf("beat%0d_data", bi), 64'(bd[bi]), 64'(gen[bi]));
            end
            bi++;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
      asi_valid = 1'b1; asi_data = '0; avm_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ready", 64'(asi_ready), 64'd0);
      chk("rst_write", 64'(avm_write), 64'd0);
      chk("rst_addr", 64'(avm_address), 64'd0);
      chk("rst_bc", 64'(avm_burstcount), 64'd0);
      chk("rst_wdata", 64'(avm_writedata), 64'd0);
      chk("rst_be", 64'(avm_byteenable), 64'hF);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", 64'(asi_ready), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      asi_valid = 1'b0;

      run_xfer(32'h0000_1000, 16, 1'b1, 100, 0, 1'b0, 0);
      run_xfer(32'h0000_1000, 11, 1'b1, 100, 0, 1'b0, 0);
      run_xfer(32'h0000_2000, 24, 1'b0, 100, 2, 1'b0, 0);
      run_xfer(32'h0000_6000, 0,  1'b0, 100, 0, 1'b0, 0);
      run_xfer(32'h0000_3000, 10, 1'b0, 100, 0, 1'b1, 0);
      run_xfer(32'hFFFF_FFE0, 16, 1'b0, 100, 0, 1'b0, 0);
      run_xfer(32'h0000_1003, 5,  1'b0, 100, 0, 1'b0, 0);
      run_xfer(32'h0000_4000, 16, 1'b0, 100, 0, 1'b0, 3);
      run_xfer(32'h0000_4000, 12, 1'b0, 100, 1, 1'b0, 0);
      for (int r = 0; r < 6; r++)
         run_xfer($urandom, int'($urandom_range(1, 40)), 1'b0,
                  int'($urandom_range(50, 100)), 1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
